// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code encodings, FSM states
// and status flag positions.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] make_status(input logic z, input logic n,
                                             input logic c, input logic v);
    logic [3:0] s;
    s         = 4'b0000;
    s[FLAG_Z] = z;
    s[FLAG_N] = n;
    s[FLAG_C] = c;
    s[FLAG_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle. The multiplier
// starts in the low half of the product register and is shifted out as the
// partial sums accumulate in the high half.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     sum_s;

  // Partial sum for the multiplier bit currently at the bottom of prod_r
  always_comb begin
    sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    if (prod_r[0]) begin
      sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
  end

  // Load on start, then iterate until the counter drains
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_r  <= '0;
      mcand_r <= '0;
      cnt_r   <= '0;
    end else if (start) begin
      prod_r  <= {{WIDTH{1'b0}}, b};
      mcand_r <= a;
      cnt_r   <= CW'(WIDTH);
    end else if (cnt_r != CW'(0)) begin
      prod_r  <= {sum_s, prod_r[WIDTH-1:1]};
      cnt_r   <= cnt_r - CW'(1);
    end
  end

  // done flags the final iteration: product is complete after this edge
  assign done    = (cnt_r == CW'(1));
  assign product = prod_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops are evaluated
// from the captured operands; MUL runs on the iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e             state_r, next_s;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, a_in_s, b_in_s, res_s;
  logic               cin_r, accept_s, in_ready_s, mul_start_s, mul_done_s;
  logic               c_s, v_s, out_valid_r;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   f_r;
  logic [3:0]         status_r;

  assign a_in_s   = FS[0] ? ~A : A;
  assign b_in_s   = FS[1] ? ~B : B;
  assign accept_s = in_valid & in_ready_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start_s),
    .a       (a_in_s),
    .b       (b_in_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_s;
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_s = (FS[4:2] == OP_MUL) ? ST_MUL : ST_DONE;
        else          next_s = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done_s) next_s = ST_DONE;
        else            next_s = ST_MUL;
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) next_s = ST_IDLE;
        else                          next_s = ST_DONE;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_s  = 1'b0;
    mul_start_s = 1'b0;
    if (state_r == ST_IDLE) begin
      in_ready_s  = 1'b1;
      mul_start_s = accept_s && (FS[4:2] == OP_MUL);
    end else begin
      in_ready_s  = 1'b0;
      mul_start_s = 1'b0;
    end
  end

  // Operand capture on handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r  <= OP_ZERO;
      a_r   <= '0;
      b_r   <= '0;
      cin_r <= 1'b0;
    end else if (accept_s) begin
      op_r  <= FS[4:2];
      a_r   <= a_in_s;
      b_r   <= b_in_s;
      cin_r <= Cin;
    end
  end

  // Result and carry/overflow from the captured operands
  always_comb begin
    sum_s = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op_r)
      OP_AND: res_s = a_r & b_r;
      OP_OR:  res_s = a_r | b_r;
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = ~(a_r[MSB] ^ b_r[MSB]) & (sum_s[MSB] ^ a_r[MSB]);
      end
      OP_XOR: res_s = a_r ^ b_r;
      OP_SHL: res_s = a_r << b_r[SW-1:0];
      OP_SHR: res_s = a_r >> b_r[SW-1:0];
      OP_MUL: begin
        res_s = mul_prod_s[WIDTH-1:0];
        v_s   = |mul_prod_s[2*WIDTH-1:WIDTH];
      end
      OP_ZERO: res_s = '0;
      default: res_s = '0;
    endcase
  end

  // Output register: loads once on entering DONE, clears on handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      f_r         <= '0;
      status_r    <= 4'b0000;
      out_valid_r <= 1'b0;
    end else if (state_r == ST_DONE && !out_valid_r) begin
      f_r         <= res_s;
      status_r    <= make_status(res_s == '0, res_s[MSB], c_s, v_s);
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign F         = f_r;
  assign status    = status_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH 64, 8 and 32 with directed vectors.
module tb_alu_seq;

  typedef struct {
    int          id;
    logic [63:0] f;
    logic [3:0]  st;
  } exp_t;

  logic        clk, rst, cin, out_ready;
  logic [4:0]  fs;
  logic [63:0] a_bus, b_bus;
  logic [2:0]  iv;
  logic        ir [3];
  logic        ov [3];
  logic [3:0]  st [3];
  logic [63:0] fv [3];
  logic [63:0] f64;
  logic [7:0]  f8;
  logic [31:0] f32;
  exp_t        q [$];
  int          n_vec, n_err;

  alu_seq #(.WIDTH(64)) u64 (
    .clock(clk), .reset(rst), .FS(fs), .A(a_bus), .B(b_bus), .Cin(cin),
    .in_valid(iv[0]), .in_ready(ir[0]), .F(f64), .status(st[0]),
    .out_valid(ov[0]), .out_ready(out_ready));

  alu_seq #(.WIDTH(8)) u8 (
    .clock(clk), .reset(rst), .FS(fs), .A(a_bus[7:0]), .B(b_bus[7:0]), .Cin(cin),
    .in_valid(iv[1]), .in_ready(ir[1]), .F(f8), .status(st[1]),
    .out_valid(ov[1]), .out_ready(out_ready));

  alu_seq #(.WIDTH(32)) u32 (
    .clock(clk), .reset(rst), .FS(fs), .A(a_bus[31:0]), .B(b_bus[31:0]), .Cin(cin),
    .in_valid(iv[2]), .in_ready(ir[2]), .F(f32), .status(st[2]),
    .out_valid(ov[2]), .out_ready(out_ready));

  always #5 clk = ~clk;

  always_comb begin
    fv[0] = f64;
    fv[1] = {56'h0, f8};
    fv[2] = {32'h0, f32};
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output id=%0d F=%h status=%b", k, fv[k], st[k]);
        end else begin
          e = q.pop_front();
          if (e.id != k || fv[k] !== e.f || st[k] !== e.st) begin
            n_err++;
            $display("FAIL result id=%0d got F=%h status=%b, exp id=%0d F=%h status=%b",
                     k, fv[k], st[k], e.id, e.f, e.st);
          end
        end
      end
    end
  end

  // Issue one command, push its expected result, check latency and busy state
  task automatic run_op(input int id, input logic [4:0] f_s, input logic [63:0] av,
                        input logic [63:0] bv, input logic c, input logic [63:0] ef,
                        input logic [3:0] es, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!ir[id] && n < 200) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 64'(ir[id]), 64'd1);
    e.id = id; e.f = ef; e.st = es;
    q.push_back(e);
    fs = f_s; a_bus = av; b_bus = bv; cin = c; iv[id] = 1'b1;
    @(posedge clk); #1;
    iv[id] = 1'b0;
    fs = ~f_s; a_bus = ~av; b_bus = ~bv; cin = ~c;
    n = 0;
    while (!ov[id] && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'(lat));
    chk("in_ready_busy", 64'(ir[id]), 64'd0);
  endtask

  initial begin
    int seen;
    clk = 1'b0; rst = 1'b1; iv = 3'b000; out_ready = 1'b1;
    fs = 5'b00000; a_bus = 64'h0; b_bus = 64'h0; cin = 1'b0;
    n_vec = 0; n_err = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_F", fv[k], 64'h0);
      chk("reset_status", 64'(st[k]), 64'h0);
      chk("reset_out_valid", 64'(ov[k]), 64'h0);
      chk("reset_in_ready", 64'(ir[k]), 64'h1);
    end
    rst = 1'b0;

    // WIDTH=64 vectors
    run_op(0, 5'b01000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101, 1);
    run_op(0, 5'b01010, 64'h5, 64'h5, 1'b1, 64'h0, 4'b1010, 1);
    run_op(0, 5'b01000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b1010, 1);
    run_op(0, 5'b01000, 64'h1, 64'h2, 1'b1, 64'h4, 4'b0000, 1);
    run_op(0, 5'b00000, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0,
           64'h0F00_0F00_0F00_0F00, 4'b0000, 1);
    run_op(0, 5'b00101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64'h0, 4'b1000, 1);
    run_op(0, 5'b01100, 64'h8000_0000_0000_0001, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b0100, 1);
    run_op(0, 5'b11111, 64'h1234, 64'h5678, 1'b1, 64'h0, 4'b1000, 1);
    run_op(0, 5'b11000, 64'h3, 64'h5, 1'b1, 64'hF, 4'b0000, 65);

    // WIDTH=8 multiplies
    run_op(1, 5'b11000, 64'h10, 64'h11, 1'b0, 64'h10, 4'b0001, 9);
    run_op(1, 5'b11000, 64'hFF, 64'hFF, 1'b0, 64'h01, 4'b0001, 9);
    run_op(1, 5'b11001, 64'hFE, 64'h80, 1'b0, 64'h80, 4'b0100, 9);

    // WIDTH=32 shifts
    run_op(2, 5'b10000, 64'h1, 64'h21, 1'b0, 64'h2, 4'b0000, 1);
    run_op(2, 5'b10100, 64'h8000_0000, 64'd31, 1'b0, 64'h1, 4'b0000, 1);
    run_op(2, 5'b10000, 64'h8000_0001, 64'h0, 1'b0, 64'h8000_0001, 4'b0100, 1);
    run_op(2, 5'b10110, 64'hFFFF_FFFF, 64'hFFFF_FFE0, 1'b0, 64'h1, 4'b0000, 1);

    // Backpressure: result held while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(0, 5'b01000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_F", f64, 64'h8000_0000_0000_0000);
      chk("bp_status", 64'(st[0]), 64'h5);
      chk("bp_out_valid", 64'(ov[0]), 64'h1);
      chk("bp_in_ready", 64'(ir[0]), 64'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(ir[0]), 64'h1);
    chk("bp_release_out_valid", 64'(ov[0]), 64'h0);

    // Reset three cycles into a WIDTH=8 multiply
    fs = 5'b11000; a_bus = 64'h10; b_bus = 64'h11; cin = 1'b0; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mul_F", fv[1], 64'h0);
    chk("rst_mul_status", 64'(st[1]), 64'h0);
    chk("rst_mul_in_ready", 64'(ir[1]), 64'h1);
    chk("rst_mul_out_valid", 64'(ov[1]), 64'h0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ov[1]) seen = 1;
    end
    chk("rst_mul_no_out_valid", 64'(seen), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port FS  input  5  function select: FS[0] inverts A, FS[1] inverts B, FS[4:2] selects the operation.
REQ-005 SHALL have ports A, B  input  WIDTH  operands.
REQ-006 SHALL have port Cin  input  1  carry-in; used by ADD only.
REQ-007 SHALL have port in_valid  input  1  operands valid; in_ready  output  1  block can accept.
REQ-008 SHALL have port F  output  WIDTH  registered result.
REQ-009 SHALL have port status  output  4  registered {Z,N,C,V}.
REQ-010 SHALL have port out_valid  output  1  F/status valid; out_ready  input  1  consumer accepts.

Function
REQ-011 SHALL accept a command only on a clock edge where in_valid and in_ready are both high, capturing FS, A, B and Cin.
REQ-012 SHALL form a = FS[0] ? ~A : A and b = FS[1] ? ~B : B.
REQ-013 SHALL encode FS[4:2] as follows: 000 AND, 001 OR, 010 ADD (a+b+Cin), 011 XOR, 100 SHL, 101 SHR, 110 MUL, 111 F=0.
REQ-014 SHALL take the shift amount for SHL/SHR from b[log2(WIDTH)-1:0]; SHR is logical.
REQ-015 SHALL compute MUL as the unsigned a*b, returning the low WIDTH bits in F.
REQ-016 SHALL use FSM states IDLE, MUL, DONE.
REQ-017 SHALL make the following transitions: IDLE to DONE on accepting a non-MUL command; IDLE to MUL on accepting a MUL command; MUL to DONE after exactly WIDTH iteration cycles; DONE to IDLE when out_ready is high.
REQ-018 SHALL set the latency of a non-MUL op accepted at edge N so that out_valid is high after edge N+1.
REQ-019 SHALL set the latency of a MUL op accepted at edge N so that out_valid is high after edge N+WIDTH+1.
REQ-020 SHALL drive in_ready high only in IDLE, so there is one command in flight and no back-to-back overlap.
REQ-021 SHALL drive out_valid high only in DONE, holding F and status stable until out_ready is sampled high.
REQ-022 SHALL set Z when F is all zeros, and N = F[WIDTH-1].
REQ-023 SHALL set C and V for ADD as follows: C = carry-out of bit WIDTH-1; V = ~(a[MSB]^b[MSB]) & (F[MSB]^a[MSB]).
REQ-024 SHALL set C and V for MUL as follows: C=0; V=1 if the upper WIDTH product bits are nonzero.
REQ-025 SHALL force C=0 and V=0 for every other operation.
REQ-026 SHALL ignore in_valid while not in IDLE; input changes in MUL/DONE never disturb the operation in flight.
REQ-027 SHALL return to IDLE on the same edge that out_valid and out_ready are both high; a new command is accepted no earlier than the following edge.

Reset
REQ-028 SHALL, when reset is high at a clock edge, go to IDLE and set F=0, status=4'b0000, out_valid=0, with in_ready=1 after that edge.
REQ-029 SHALL let reset during MUL or DONE abandon the operation, with no out_valid pulse for it afterwards.
REQ-030 SHALL give reset priority over a simultaneous in_valid/in_ready handshake, so that no command is accepted.

Structure
REQ-031 SHALL place the op-code constants (FS[4:2] encodings), the FSM state enum and the status bit indices in a shared package alu_pkg.
REQ-032 SHALL implement MUL in one sub-module alu_mul_seq (shift-add, one bit per cycle, 2*WIDTH product register, start/done pins).
REQ-033 SHALL keep the logic ops, add and shifts combinational from the captured operands inside alu_seq.

Verification
REQ-034 SHALL verify ADD at WIDTH=64: FS=01000, A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> after 1 cycle F=0x8000_0000_0000_0000, status=0101 (N,V).
REQ-035 SHALL verify SUB at WIDTH=64: FS=01010, A=5, B=5, Cin=1 -> F=0, status=1010 (Z,C).
REQ-036 SHALL verify MUL at WIDTH=8: FS=11000, A=0x10, B=0x11 -> out_valid exactly 9 cycles after accept, F=0x10, status=0001 (V).
REQ-037 SHALL verify backpressure: out_ready held low 5 cycles in DONE -> F/status/out_valid stable, in_ready low; release -> IDLE next edge.
REQ-038 SHALL verify reset mid-MUL: reset asserted 3 cycles into MUL -> F=0, status=0, in_ready=1 next cycle, out_valid never asserted for that op.
REQ-039 SHALL verify shifts at WIDTH=32: FS=10000, A=1, B=0x21 -> F=2 (shift amount 1); FS=10100, A=0x8000_0000, B=31 -> F=1.
